// File: rtl/ecc_secded_pipe.sv
// SECDED (extended Hamming) encoder plus pipelined read-side checker/corrector with error stats.
// Latency: encode combinational; check/correct 2 cycles in_valid -> out_valid, one word per cycle.
// Backpressure: valid/ready; stages hold while out_valid & !out_ready, in_ready drops only when both stages are full.
module ecc_secded_pipe #(
    parameter int DATA_WIDTH = 31,
    parameter int CNT_WIDTH  = 16,
    localparam int PARITY_WIDTH = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   enc_data,
    output logic [PARITY_WIDTH-1:0] enc_parity,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [PARITY_WIDTH-1:0] in_parity,
    input  logic                    in_bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sbit_err,
    output logic                    out_dbit_err,
    input  logic                    cnt_clr,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic                    first_err_vld,
    output logic [PARITY_WIDTH-1:0] first_err_syn
);
    localparam int R = PARITY_WIDTH - 1;

    // Codeword position of data bit idx: the (idx+1)-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int p;
        int n;
        p = 0;
        n = -1;
        while (n < idx) begin
            p = p + 1;
            if ((p & (p - 1)) != 0) n = n + 1;
        end
        return p;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] chk_mask(input int k);
        logic [DATA_WIDTH-1:0] m;
        int p;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p = data_pos(i);
            m[i] = p[k];
        end
        return m;
    endfunction

    localparam logic [R-1:0] MAX_POS = R'(data_pos(DATA_WIDTH - 1));

    logic [R-1:0]          enc_chk;
    logic [R-1:0]          rd_chk;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_byp;
    logic [R-1:0]          s1_syn;
    logic                  s1_ov;
    logic [DATA_WIDTH-1:0] flip_hit;
    logic [DATA_WIDTH-1:0] corr_data;
    logic                  cls_sbit;
    logic                  cls_dbit;
    logic                  syn_nz;
    logic                  syn_pow2;
    logic [PARITY_WIDTH-1:0] out_syn;
    logic                  out_adv;
    logic                  in_acc;
    logic                  out_hs;

    for (genvar k = 0; k < R; k++) begin : g_chk
        localparam logic [DATA_WIDTH-1:0] MASK = chk_mask(k);
        assign enc_chk[k] = ^(enc_data & MASK);
        assign rd_chk[k]  = ^(in_data & MASK);
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_hit
        assign flip_hit[i] = (s1_syn == R'(data_pos(i)));
    end

    assign enc_parity = {(^enc_data) ^ (^enc_chk), enc_chk};

    assign out_adv  = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || out_adv);
    assign in_acc   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    assign syn_nz   = |s1_syn;
    assign syn_pow2 = syn_nz && ((s1_syn & (s1_syn - R'(1))) == '0);

    // Non-zero, non-power-of-two syndromes up to MAX_POS always name a data bit.
    always_comb begin
        corr_data = s1_data;
        cls_sbit  = 1'b0;
        cls_dbit  = 1'b0;
        if (!s1_byp) begin
            if (!s1_ov) begin
                cls_dbit = syn_nz;
            end else if (!syn_nz || syn_pow2) begin
                cls_sbit = 1'b1;
            end else if (s1_syn <= MAX_POS) begin
                cls_sbit  = 1'b1;
                corr_data = s1_data ^ flip_hit;
            end else begin
                cls_dbit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_byp        <= 1'b0;
            s1_syn        <= '0;
            s1_ov         <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sbit_err  <= 1'b0;
            out_dbit_err  <= 1'b0;
            out_syn       <= '0;
            sbit_cnt      <= '0;
            dbit_cnt      <= '0;
            first_err_vld <= 1'b0;
            first_err_syn <= '0;
        end else begin
            if (out_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data     <= corr_data;
                    out_sbit_err <= cls_sbit;
                    out_dbit_err <= cls_dbit;
                    out_syn      <= {s1_ov, s1_syn};
                end
            end

            if (in_acc) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_byp   <= in_bypass;
                s1_syn   <= rd_chk ^ in_parity[R-1:0];
                s1_ov    <= (^in_data) ^ (^in_parity);
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end

            // Clear takes priority over a coincident error handshake.
            if (cnt_clr) begin
                sbit_cnt      <= '0;
                dbit_cnt      <= '0;
                first_err_vld <= 1'b0;
                first_err_syn <= '0;
            end else if (out_hs && (out_sbit_err || out_dbit_err)) begin
                if (out_sbit_err && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
                if (out_dbit_err && dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_syn <= out_syn;
                end
            end
        end
    end

endmodule
